// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          CNT_W     = 16;

    typedef enum logic {
        REQ = 1'b0,
        BUF = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_RST = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};
    localparam ifid_t BUF_CLR  = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};

    // Squashed slot: NOP with Valid cleared, PC+4 field kept as-is.
    function automatic ifid_t make_bubble(input logic [31:0] pcplus4);
        return '{instr: NOP_INSTR, pcplus4: pcplus4, valid: 1'b0};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and PC/hazard/imem/decode logic.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [31:0]      CurrPC;
    logic             IFIDwrite;
    logic             Flush;
    logic [31:0]      imem_rdata;
    logic             imem_ready;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic [31:0]      PCplus4;
    logic             FetchStall;
    logic [31:0]      Instr_ID;
    logic [31:0]      PCplus4_ID;
    logic             Valid_ID;
    logic [CNT_W-1:0] StallCount;

    modport slave (
        input  CurrPC, IFIDwrite, Flush, imem_rdata, imem_ready,
        output imem_req, imem_addr, PCplus4, FetchStall,
               Instr_ID, PCplus4_ID, Valid_ID, StallCount
    );

    modport master (
        output CurrPC, IFIDwrite, Flush, imem_rdata, imem_ready,
        input  imem_req, imem_addr, PCplus4, FetchStall,
               Instr_ID, PCplus4_ID, Valid_ID, StallCount
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// 65-bit enable/clear register holding {Instr, PCplus4, Valid}.
// Used both as the IF/ID pipeline register and as the stall buffer.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter ifid_t CLR_VAL = IFID_RST
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_en,
    input  logic  i_clr,
    input  ifid_t i_d,
    output ifid_t o_q
);
    ifid_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= CLR_VAL;
        end else if (i_clr) begin
            r_q <= CLR_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: imem request, wait-state absorption, stall buffer, IF/ID.
// state | meaning:  REQ | fetch outstanding for CurrPC;  BUF | word held while decode stalled
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);
    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    ifid_t            r_ifid;
    ifid_t            r_buf;
    ifid_t            w_ifid_d;
    ifid_t            w_buf_d;
    logic             w_ifid_en;
    logic             w_buf_en;
    logic             w_buf_clr;
    logic             w_fetch_stall;
    logic [31:0]      w_pcplus4;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_pcplus4     = bus.CurrPC + 32'd4;
    // Held high through reset so the PC stays put while it is initialised.
    assign w_fetch_stall = rst | ((r_state == REQ) & ~bus.imem_ready);
    assign w_buf_d       = '{instr: bus.imem_rdata, pcplus4: w_pcplus4, valid: 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_ifid_en   = 1'b0;
        w_ifid_d    = r_ifid;
        w_buf_en    = 1'b0;
        w_buf_clr   = 1'b0;
        if (bus.Flush) begin
            w_ifid_en   = 1'b1;
            w_ifid_d    = make_bubble(r_ifid.pcplus4);
            w_buf_clr   = 1'b1;
            w_state_nxt = REQ;
        end else begin
            case (r_state)
                REQ: begin
                    if (bus.imem_ready) begin
                        if (bus.IFIDwrite) begin
                            w_ifid_en = 1'b1;
                            w_ifid_d  = w_buf_d;
                        end else begin
                            w_buf_en    = 1'b1;
                            w_state_nxt = BUF;
                        end
                    end else if (bus.IFIDwrite) begin
                        w_ifid_en = 1'b1;
                        w_ifid_d  = make_bubble(r_ifid.pcplus4);
                    end
                end
                BUF: begin
                    if (bus.IFIDwrite) begin
                        w_ifid_en   = 1'b1;
                        w_ifid_d    = r_buf;
                        w_state_nxt = REQ;
                    end
                end
                default: w_state_nxt = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_fetch_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    if_id_reg #(.CLR_VAL(IFID_RST)) u_ifid (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_ifid_en),
        .i_clr (1'b0),
        .i_d   (w_ifid_d),
        .o_q   (r_ifid)
    );

    if_id_reg #(.CLR_VAL(BUF_CLR)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_buf_en),
        .i_clr (w_buf_clr),
        .i_d   (w_buf_d),
        .o_q   (r_buf)
    );

    assign bus.imem_req   = ~rst & (r_state == REQ);
    assign bus.imem_addr  = bus.CurrPC;
    assign bus.PCplus4    = w_pcplus4;
    assign bus.FetchStall = w_fetch_stall;
    assign bus.Instr_ID   = r_ifid.instr;
    assign bus.PCplus4_ID = r_ifid.pcplus4;
    assign bus.Valid_ID   = r_ifid.valid;
    assign bus.StallCount = r_stall_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: IF/ID contents, a 0/1-entry holding queue, stall tally.
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_bq_instr[$];
    logic [31:0] m_bq_pc4[$];
    int          m_cnt;

    function automatic logic [31:0] add4(input logic [31:0] a);
        logic [32:0] s;
        s = {1'b0, a} + 33'd4;
        return s[31:0];
    endfunction

    function automatic logic exp_req();
        return !rst && (m_bq_instr.size() == 0);
    endfunction

    function automatic logic exp_stall();
        return rst || ((m_bq_instr.size() == 0) && !bus.imem_ready);
    endfunction

    task automatic model_reset();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_bq_instr.delete();
        m_bq_pc4.delete();
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (exp_stall() && m_cnt < 65535) m_cnt++;
            if (bus.Flush) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                m_bq_instr.delete();
                m_bq_pc4.delete();
            end else if (m_bq_instr.size() != 0) begin
                if (bus.IFIDwrite) begin
                    m_instr = m_bq_instr.pop_front();
                    m_pc4   = m_bq_pc4.pop_front();
                    m_valid = 1'b1;
                end
            end else if (bus.imem_ready) begin
                if (bus.IFIDwrite) begin
                    m_instr = bus.imem_rdata;
                    m_pc4   = add4(bus.CurrPC);
                    m_valid = 1'b1;
                end else begin
                    m_bq_instr.push_back(bus.imem_rdata);
                    m_bq_pc4.push_back(add4(bus.CurrPC));
                end
            end else if (bus.IFIDwrite) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end
        end
    endtask

    initial model_reset();

    // Compare process: inputs change at negedge, check at negedge+2, advance model at posedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("imem_req",   {31'b0, bus.imem_req},   {31'b0, exp_req()});
            chk("imem_addr",  bus.imem_addr,           bus.CurrPC);
            chk("PCplus4",    bus.PCplus4,             add4(bus.CurrPC));
            chk("FetchStall", {31'b0, bus.FetchStall}, {31'b0, exp_stall()});
            chk("Instr_ID",   bus.Instr_ID,            m_instr);
            chk("PCplus4_ID", bus.PCplus4_ID,          m_pc4);
            chk("Valid_ID",   {31'b0, bus.Valid_ID},   {31'b0, m_valid});
            chk("StallCount", {16'b0, bus.StallCount}, m_cnt[31:0]);
            @(posedge clk);
            model_edge();
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] rd,
                         input logic rdy, input logic wr, input logic fl);
        @(negedge clk);
        bus.CurrPC     = pc;
        bus.imem_rdata = rd;
        bus.imem_ready = rdy;
        bus.IFIDwrite  = wr;
        bus.Flush      = fl;
    endtask

    initial begin
        bus.CurrPC     = 32'h0;
        bus.imem_rdata = 32'h0;
        bus.imem_ready = 1'b0;
        bus.IFIDwrite  = 1'b0;
        bus.Flush      = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset state
        drive(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        drive(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("rst Instr_ID",   bus.Instr_ID, 32'h0);
        chk("rst Valid_ID",   {31'b0, bus.Valid_ID}, 32'h0);
        chk("rst StallCount", {16'b0, bus.StallCount}, 32'h0);
        chk("rst imem_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("rst FetchStall", {31'b0, bus.FetchStall}, 32'h1);

        // Zero-wait fetch
        @(negedge clk);
        rst = 1'b0;
        bus.CurrPC = 32'h0040_0020; bus.imem_rdata = 32'h2008_0005;
        bus.imem_ready = 1'b1; bus.IFIDwrite = 1'b1; bus.Flush = 1'b0;
        #1;
        chk("zw FetchStall", {31'b0, bus.FetchStall}, 32'h0);
        chk("zw imem_req",   {31'b0, bus.imem_req}, 32'h1);

        // Three wait states then the word
        drive(32'h0040_0024, 32'h8C09_0010, 1'b0, 1'b1, 1'b0);
        #1;
        chk("zw Instr_ID",   bus.Instr_ID, 32'h2008_0005);
        chk("zw PCplus4_ID", bus.PCplus4_ID, 32'h0040_0024);
        chk("zw Valid_ID",   {31'b0, bus.Valid_ID}, 32'h1);
        chk("ws FetchStall", {31'b0, bus.FetchStall}, 32'h1);
        drive(32'h0040_0024, 32'h8C09_0010, 1'b0, 1'b1, 1'b0);
        drive(32'h0040_0024, 32'h8C09_0010, 1'b0, 1'b1, 1'b0);
        drive(32'h0040_0024, 32'h8C09_0010, 1'b1, 1'b1, 1'b0);
        #1;
        chk("ws StallCount", {16'b0, bus.StallCount}, 32'd3);
        chk("ws bubble",     {31'b0, bus.Valid_ID}, 32'h0);
        chk("ws bubble NOP", bus.Instr_ID, 32'h0);

        // Decode stalled: word goes into the buffer
        drive(32'h0040_0028, 32'h0109_5020, 1'b1, 1'b0, 1'b0);
        #1;
        chk("ws Instr_ID",   bus.Instr_ID, 32'h8C09_0010);
        chk("ws PCplus4_ID", bus.PCplus4_ID, 32'h0040_0028);
        drive(32'h0040_0028, 32'h0109_5020, 1'b1, 1'b0, 1'b0);
        #1;
        chk("buf imem_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("buf FetchStall", {31'b0, bus.FetchStall}, 32'h0);
        chk("buf hold Instr", bus.Instr_ID, 32'h8C09_0010);
        drive(32'h0040_0028, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        drive(32'h0040_002C, 32'hAAAA_5555, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rel Instr_ID",   bus.Instr_ID, 32'h0109_5020);
        chk("rel PCplus4_ID", bus.PCplus4_ID, 32'h0040_002C);
        chk("rel Valid_ID",   {31'b0, bus.Valid_ID}, 32'h1);

        // Flush while in BUF
        drive(32'h0040_002C, 32'hAAAA_5555, 1'b1, 1'b0, 1'b1);
        #1;
        chk("pre-flush imem_req", {31'b0, bus.imem_req}, 32'h0);
        drive(32'hFFFF_FFFC, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush Instr_ID",   bus.Instr_ID, 32'h0);
        chk("flush Valid_ID",   {31'b0, bus.Valid_ID}, 32'h0);
        chk("flush PCplus4_ID", bus.PCplus4_ID, 32'h0040_002C);
        chk("flush imem_req",   {31'b0, bus.imem_req}, 32'h1);
        chk("wrap PCplus4",     bus.PCplus4, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0));
        end

        // Async reset mid-BUF
        drive(32'h0000_0100, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        drive(32'h0000_0104, 32'h8765_4321, 1'b1, 1'b0, 1'b0);
        drive(32'h0000_0108, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);
        #1;
        chk("pre-rst Instr_ID", bus.Instr_ID, 32'h1234_5678);
        chk("pre-rst imem_req", {31'b0, bus.imem_req}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst Instr_ID",   bus.Instr_ID, 32'h0);
        chk("arst PCplus4_ID", bus.PCplus4_ID, 32'h0);
        chk("arst Valid_ID",   {31'b0, bus.Valid_ID}, 32'h0);
        chk("arst StallCount", {16'b0, bus.StallCount}, 32'h0);
        chk("arst imem_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("arst FetchStall", {31'b0, bus.FetchStall}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.CurrPC = 32'h0040_0000; bus.imem_rdata = 32'h2402_0001;
        bus.imem_ready = 1'b1; bus.IFIDwrite = 1'b1; bus.Flush = 1'b0;
        drive(32'h0040_0004, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("restart Instr_ID",   bus.Instr_ID, 32'h2402_0001);
        chk("restart PCplus4_ID", bus.PCplus4_ID, 32'h0040_0004);
        chk("restart Valid_ID",   {31'b0, bus.Valid_ID}, 32'h1);
        @(negedge clk);
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
